// File: rtl/pcf8574_writer.sv
// pcf8574_writer: writes one byte to a PCF8574 expander through a command-level I2C engine,
// with NACK retries and response timeouts.
module pcf8574_writer #(
  parameter logic [6:0] DEV_ADDR = 7'h20,
  parameter int RETRY_MAX = 3,
  parameter int unsigned TIMEOUT = 2**24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_data,
  input  logic       i2c_busy,
  input  logic       i2c_nack,
  output logic       done,
  output logic       fail,
  output logic [7:0] port_shadow
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK} state_t;
  typedef enum logic [1:0] {ST_START, ST_ADDR, ST_DATA, ST_STOP} step_t;
  state_t      r_state;
  step_t       r_step;
  logic [7:0]  r_byte;
  logic [2:0]  r_retry;
  logic        r_retry_flag;
  logic        r_nack;
  logic [31:0] r_cnt;
  logic [1:0]  w_op;
  logic [7:0]  w_data;
  assign wr_ready = r_state == IDLE;
  always_comb begin
    w_op = r_step == ST_START ? 2'd0 : r_step == ST_STOP ? 2'd2 : 2'd1;
    w_data = r_step == ST_ADDR ? {DEV_ADDR, 1'b0} : r_step == ST_DATA ? r_byte : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_step       <= ST_START;
      r_byte       <= 8'h00;
      r_retry      <= 3'd0;
      r_retry_flag <= 1'b0;
      r_nack       <= 1'b0;
      r_cnt        <= 32'd0;
      cmd_valid    <= 1'b0;
      cmd_op       <= 2'd0;
      cmd_data     <= 8'h00;
      done         <= 1'b0;
      fail         <= 1'b0;
      port_shadow  <= 8'hFF;
    end else begin
      cmd_valid <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      case (r_state)
        IDLE: begin
          r_retry <= 3'd0;
          if (wr_valid) begin
            r_byte       <= wr_data;
            r_step       <= ST_START;
            r_retry_flag <= 1'b0;
            r_state      <= ISSUE;
          end
        end
        ISSUE: if (!i2c_busy) begin
          cmd_valid <= 1'b1;
          cmd_op    <= w_op;
          cmd_data  <= w_data;
          r_cnt     <= 32'd0;
          r_state   <= WAIT_HI;
        end
        WAIT_HI: if (i2c_busy) begin
          r_cnt   <= 32'd0;
          r_state <= WAIT_LO;
        end else if (r_cnt == 32'd3) begin
          fail    <= 1'b1;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + 32'd1;
        WAIT_LO: if (!i2c_busy) begin
          r_nack  <= i2c_nack;
          r_state <= CHECK;
        end else if (r_cnt == 32'(TIMEOUT - 1)) begin
          fail    <= 1'b1;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + 32'd1;
        CHECK: begin
          r_state <= ISSUE;
          if (r_step == ST_START) r_step <= ST_ADDR;
          else if (r_step != ST_STOP) begin
            r_step <= r_nack ? ST_STOP : step_t'(r_step + 2'd1);
            if (r_nack) r_retry_flag <= 1'b1;
          end else if (!r_retry_flag) begin
            done        <= 1'b1;
            port_shadow <= r_byte;
            r_state     <= IDLE;
          end else if (r_retry < 3'(RETRY_MAX)) begin
            r_retry      <= r_retry + 3'd1;
            r_retry_flag <= 1'b0;
            r_step       <= ST_START;
          end else begin
            fail    <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pcf8574_writer.md
PCF8574_WRITER -- requirements
Module: pcf8574_writer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h20, which is the 7-bit I2C address of the PCF8574 expander.
REQ-002 SHALL have parameter RETRY_MAX, default 3, which is the number of re-attempts allowed after a NACK (range 0-7).
REQ-003 SHALL have parameter TIMEOUT, default 2**24, which is the maximum cycles a single bus operation may keep i2c_busy high.
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic is on posedge.
REQ-005 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_valid, input, width 1: host offers a port value.
REQ-007 SHALL have port wr_data, input, width 8: the port value to drive on P7..P0.
REQ-008 SHALL have port wr_ready, output, width 1: the block accepts wr_data.
REQ-009 SHALL have port cmd_valid, output, width 1: a one-cycle command strobe to the downstream I2C bit engine.
REQ-010 SHALL have port cmd_op, output, width 2: 0=START, 1=WRITE, 2=STOP.
REQ-011 SHALL have port cmd_data, output, width 8: the byte sent on WRITE.
REQ-012 SHALL have port i2c_busy, input, width 1: the downstream engine is executing a command.
REQ-013 SHALL have port i2c_nack, input, width 1: the ack bit of the last WRITE (1 = NACK), valid on the busy falling edge.
REQ-014 SHALL have port done, output, width 1: one-cycle pulse when a transaction succeeds.
REQ-015 SHALL have port fail, output, width 1: one-cycle pulse when a transaction is abandoned.
REQ-016 SHALL have port port_shadow, output, width 8: the last value successfully written.

Function
REQ-017 The handshake SHALL be: wr_ready=1 only in IDLE; transfer on wr_valid&&wr_ready; wr_data is captured into an internal byte register on transfer.
REQ-018 The FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK.
- Each bus step uses ISSUE, WAIT_HI, WAIT_LO.
- The step sequence is START, ADDR, DATA, STOP.
REQ-019 ISSUE SHALL assert cmd_valid for exactly one cycle with cmd_op/cmd_data for the current step, then go to WAIT_HI.
- ISSUE is entered only when i2c_busy=0; otherwise it waits.
REQ-020 The ADDR step SHALL send cmd_data = {DEV_ADDR,1'b0}; the DATA step SHALL send the captured byte; START and STOP SHALL send cmd_data=8'h00.
REQ-021 WAIT_HI SHALL wait for i2c_busy=1.
- If busy does not rise within 4 cycles of the cmd_valid strobe, the transaction fails (REQ-026).
REQ-022 WAIT_LO SHALL wait for i2c_busy=0, then go to CHECK.
- A 32-bit counter limits the wait to TIMEOUT cycles; on expiry the transaction fails.
REQ-023 CHECK SHALL evaluate the completed step.
- After ADDR or DATA: i2c_nack=0 advances to the next step.
- After ADDR or DATA: i2c_nack=1 goes to STOP, with a retry flagged.
- After START: advances to ADDR.
- After STOP: see REQ-024/REQ-025.
REQ-024 After STOP with no retry flagged, the block SHALL pulse done, load port_shadow with the captured byte, and return to IDLE.
REQ-025 After STOP with a retry flagged, the block SHALL behave as follows:
- If retry_count < RETRY_MAX: increment retry_count and restart at START with the same byte.
- Otherwise: pulse fail, leave port_shadow unchanged, and return to IDLE.
REQ-026 A timeout failure SHALL pulse fail and go directly to IDLE with no STOP issued; retry_count SHALL be cleared on every return to IDLE.
REQ-027 cmd_valid SHALL never be asserted while i2c_busy=1, and never on two consecutive cycles.
REQ-028 done and fail SHALL be mutually exclusive and each SHALL be high for exactly one cycle per transaction.
REQ-029 When wr_valid is held high continuously, back-to-back transactions SHALL start on the cycle after done/fail, when wr_ready is high.

Reset
REQ-030 On rst=1 at a clock edge the block SHALL set state to IDLE, wr_ready=1 from the next cycle, cmd_valid=0, cmd_op=0, cmd_data=8'h00, done=0, fail=0, port_shadow=8'hFF (the PCF8574 power-up value), retry_count=0, and counters to 0.
REQ-031 A reset mid-transaction SHALL abandon the transaction with no STOP issued and no done/fail pulse.

Verification
REQ-032 Nominal write: wr_data=8'hA5, a model acks everything with 3-cycle busy -> command order START, WRITE 8'h40, WRITE 8'hA5, STOP; one done pulse; port_shadow=8'hA5.
REQ-033 Address NACK once: the model NACKs the first 8'h40 -> START, WRITE 8'h40, STOP, START, WRITE 8'h40, WRITE data, STOP; done=1; no fail.
REQ-034 Persistent NACK with RETRY_MAX=3 -> exactly 4 attempts, each ending in STOP, then one fail pulse; port_shadow stays 8'hFF.
REQ-035 Busy stuck: the model holds busy high with TIMEOUT=16 -> fail pulses 16-18 cycles after the strobe; the block returns to IDLE; wr_ready=1.
REQ-036 No response: the model never raises busy -> fail within 4 cycles of cmd_valid.
REQ-037 Reset during the DATA step -> next cycle in IDLE, cmd_valid=0, no pulses; port_shadow keeps its previous value or 8'hFF per REQ-030.
